// File: rtl/ram_ctrl.sv
// ram_ctrl: initiator-side controller for a single-port RAM on a shared,
// bidirectional data bus. It takes one valid/ready request at a time, drives
// wr_en/re_en/addr and owns the bus direction, inserting TURN_CYC idle cycles
// after every read so the RAM and the controller never drive the bus together.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// req_ready is high only while idle; the client holds the request until then.
//
// Optional build macro RAM_CTRL_STATS_EN adds wr_count/rd_count completion
// counters (16-bit, wrapping). Without it those ports and counters do not exist.
module ram_ctrl #(
    parameter int DATA_WIDE = 32,
    parameter int DEEP      = 512,
    parameter int ADDR_WIDE = $clog2(DEEP),
    parameter int WR_CYC    = 2,
    parameter int RD_LAT    = 2,
    parameter int TURN_CYC  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADDR_WIDE-1:0] req_addr,
    input  logic [DATA_WIDE-1:0] req_wdata,
    output logic                 done,
    output logic                 rd_valid,
    output logic [DATA_WIDE-1:0] rd_data,
    output logic                 mem_wr_en,
    output logic                 mem_re_en,
    output logic [ADDR_WIDE-1:0] mem_addr,
`ifdef RAM_CTRL_STATS_EN
    output logic [15:0]          wr_count,
    output logic [15:0]          rd_count,
`endif
    inout  wire  [DATA_WIDE-1:0] mem_data_io
);

    // One down-counter serves all three timed states; size it for the largest load.
    localparam int WR_LOAD   = WR_CYC - 1;
    localparam int TURN_LOAD = (TURN_CYC > 0) ? TURN_CYC - 1 : 0;
    localparam int MAX_A     = (WR_LOAD > RD_LAT) ? WR_LOAD : RD_LAT;
    localparam int CNT_MAX   = (MAX_A > TURN_LOAD) ? MAX_A : TURN_LOAD;
    localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_TURN  = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 req_ready_q, req_ready_d;
    logic                 done_q, done_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [DATA_WIDE-1:0] rd_data_q, rd_data_d;
    logic                 mem_wr_en_q, mem_wr_en_d;
    logic                 mem_re_en_q, mem_re_en_d;
    logic [ADDR_WIDE-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDE-1:0] wdata_q, wdata_d;
    logic                 drive_q, drive_d;
`ifdef RAM_CTRL_STATS_EN
    logic [15:0]          wr_count_q, wr_count_d;
    logic [15:0]          rd_count_q, rd_count_d;
`endif

    logic accept;
    logic last_cyc;

    assign accept   = req_valid && req_ready_q;
    assign last_cyc = (cnt_q == '0);

    // State register and all registered outputs; async reset drops strobes and bus drive at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            done_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            mem_wr_en_q <= 1'b0;
            mem_re_en_q <= 1'b0;
            mem_addr_q  <= '0;
            wdata_q     <= '0;
            drive_q     <= 1'b0;
`ifdef RAM_CTRL_STATS_EN
            wr_count_q  <= '0;
            rd_count_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            done_q      <= done_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            mem_wr_en_q <= mem_wr_en_d;
            mem_re_en_q <= mem_re_en_d;
            mem_addr_q  <= mem_addr_d;
            wdata_q     <= wdata_d;
            drive_q     <= drive_d;
`ifdef RAM_CTRL_STATS_EN
            wr_count_q  <= wr_count_d;
            rd_count_q  <= rd_count_d;
`endif
        end
    end

    // Next-state and cycle counter: each timed state ends on the edge where cnt reaches zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (req_we) begin
                        state_d = S_WRITE;
                        cnt_d   = CNT_W'(WR_LOAD);
                    end else begin
                        state_d = S_READ;
                        cnt_d   = CNT_W'(RD_LAT);
                    end
                end
            end
            S_WRITE: begin
                if (last_cyc) state_d = S_IDLE;
                else          cnt_d   = cnt_q - CNT_W'(1);
            end
            S_READ: begin
                if (last_cyc) begin
                    if (TURN_CYC > 0) begin
                        state_d = S_TURN;
                        cnt_d   = CNT_W'(TURN_LOAD);
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_TURN: begin
                if (last_cyc) state_d = S_IDLE;
                else          cnt_d   = cnt_q - CNT_W'(1);
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output next-values: strobes follow the state being entered, pulses mark the final cycle.
    always_comb begin
        req_ready_d = (state_d == S_IDLE);
        mem_wr_en_d = (state_d == S_WRITE);
        drive_d     = (state_d == S_WRITE);
        mem_re_en_d = (state_d == S_READ);
        rd_valid_d  = (state_q == S_READ) && last_cyc;
        done_d      = ((state_q == S_WRITE) || (state_q == S_READ)) && last_cyc;
        rd_data_d   = rd_valid_d ? mem_data_io : rd_data_q;
        mem_addr_d  = accept ? req_addr : mem_addr_q;
        wdata_d     = accept ? req_wdata : wdata_q;
`ifdef RAM_CTRL_STATS_EN
        wr_count_d  = wr_count_q + {15'd0, ((state_q == S_WRITE) && last_cyc)};
        rd_count_d  = rd_count_q + {15'd0, rd_valid_d};
`endif
    end

    assign req_ready   = req_ready_q;
    assign done        = done_q;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;
    assign mem_wr_en   = mem_wr_en_q;
    assign mem_re_en   = mem_re_en_q;
    assign mem_addr    = mem_addr_q;
    assign mem_data_io = drive_q ? wdata_q : {DATA_WIDE{1'bz}};
`ifdef RAM_CTRL_STATS_EN
    assign wr_count    = wr_count_q;
    assign rd_count    = rd_count_q;
`endif

endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: randomized scoreboard bench for ram_ctrl with a behavioural
// RAM on the shared bus and a bus keeper that drives a changing pattern
// whenever neither strobe is high, so any stray controller drive shows up.
module tb_ram_ctrl;

    localparam int DW       = 32;
    localparam int DEEP     = 512;
    localparam int AW       = 9;
    localparam int WR_CYC   = 2;
    localparam int RD_LAT   = 2;
    localparam int TURN_CYC = 1;
    localparam int WR_BUSY  = WR_CYC;
    localparam int RD_BUSY  = RD_LAT + 1 + TURN_CYC;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic          req_valid = 1'b0;
    logic          req_we    = 1'b0;
    logic [AW-1:0] req_addr  = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          req_ready, done, rd_valid, mem_wr_en, mem_re_en;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] mem_addr;
    wire  [DW-1:0] mem_data_io;
`ifdef RAM_CTRL_STATS_EN
    logic [15:0]   wr_count, rd_count;
`endif

    ram_ctrl #(
        .DATA_WIDE (DW),
        .DEEP      (DEEP),
        .ADDR_WIDE (AW),
        .WR_CYC    (WR_CYC),
        .RD_LAT    (RD_LAT),
        .TURN_CYC  (TURN_CYC)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .done        (done),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_re_en   (mem_re_en),
        .mem_addr    (mem_addr),
`ifdef RAM_CTRL_STATS_EN
        .wr_count    (wr_count),
        .rd_count    (rd_count),
`endif
        .mem_data_io (mem_data_io)
    );

    // ---------------- RAM and bus keeper ----------------
    logic [DW-1:0] ram_mem [DEEP];
    logic [DW-1:0] ref_mem [DEEP];
    logic [DW-1:0] ram_rdata;
    logic [DW-1:0] keep_val = 32'h5a5a_c3c3;

    assign ram_rdata   = ram_mem[mem_addr];
    assign mem_data_io = mem_re_en ? ram_rdata : {DW{1'bz}};
    assign mem_data_io = (!mem_re_en && !mem_wr_en) ? keep_val : {DW{1'bz}};

    always @(posedge clk) if (mem_wr_en) ram_mem[mem_addr] <= mem_data_io;
    always @(posedge clk) keep_val <= $urandom;

    function automatic logic [DW-1:0] init_word(input int i);
        return (i * 32'h9e37_79b1) ^ 32'h1357_9bdf;
    endfunction

    // ---------------- scoreboard state ----------------
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] exp_q[$];
    logic          exp_rd_q[$];
    int            exp_cyc_q[$];

    bit            mon_en    = 1'b0;
    int            cur_acc   = -1000;
    logic          cur_we    = 1'b0;
    logic [AW-1:0] cur_addr  = '0;
    logic [DW-1:0] cur_wdata = '0;
    logic [DW-1:0] last_rd   = '0;
    int            last_acc  = -1000;
    int            last_period = 0;
    int            n_wr_model = 0;
    int            n_rd_model = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        logic          ew, er, erdy, prd;
        logic [DW-1:0] eb, pdata;
        int            pcyc;
        if (rst_n && mon_en) begin
            ew   = cur_we  && (cyc >= cur_acc) && (cyc < cur_acc + WR_BUSY);
            er   = !cur_we && (cyc >= cur_acc) && (cyc < cur_acc + RD_LAT + 1);
            erdy = !((cyc >= cur_acc) && (cyc < cur_acc + (cur_we ? WR_BUSY : RD_BUSY)));
            check("mem_wr_en", mem_wr_en, ew);
            check("mem_re_en", mem_re_en, er);
            check("req_ready", req_ready, erdy);
            check("strobe_overlap", mem_wr_en & mem_re_en, 0);
            if (mem_wr_en || mem_re_en) check("mem_addr", mem_addr, cur_addr);
            eb = mem_wr_en ? cur_wdata : (mem_re_en ? ram_rdata : keep_val);
            check("bus_value", mem_data_io, eb);
            if (done) begin
                if (exp_cyc_q.size() == 0) begin
                    check("unexpected_done", done, 0);
                end else begin
                    pdata = exp_q.pop_front();
                    prd   = exp_rd_q.pop_front();
                    pcyc  = exp_cyc_q.pop_front();
                    check("done_cycle", cyc, pcyc);
                    check("rd_valid", rd_valid, prd);
                    if (prd) begin
                        check("rd_data", rd_data, pdata);
                        last_rd = pdata;
                        n_rd_model++;
                    end else begin
                        check("rd_data_hold", rd_data, last_rd);
                        n_wr_model++;
                    end
                end
            end else begin
                check("rd_valid_no_done", rd_valid, 0);
                check("rd_data_hold", rd_data, last_rd);
                if (exp_cyc_q.size() > 0 && cyc > exp_cyc_q[0]) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL done_timeout: no done by cycle %0d, expected at %0d", cyc, exp_cyc_q[0]);
                    void'(exp_q.pop_front());
                    void'(exp_rd_q.pop_front());
                    void'(exp_cyc_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic junk_inputs();
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = AW'($urandom);
        req_wdata = $urandom;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            junk_inputs();
            @(posedge clk);
            #1;
        end
    endtask

    // Called and returns 1 time unit after a rising edge.
    task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        int exp_acc;
        bit acc;
        acc       = 1'b0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = data;
        exp_acc   = cyc + 1;
        if (last_acc + last_period > exp_acc) exp_acc = last_acc + last_period;
        for (int k = 0; k < 64 && !acc; k++) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: request never accepted by cycle %0d", cyc);
        end else begin
            check("accept_cycle", cyc, exp_acc);
            cur_acc   = cyc;
            cur_we    = we;
            cur_addr  = addr;
            cur_wdata = data;
            if (we) begin
                ref_mem[addr] = data;
                exp_q.push_back('0);
                exp_rd_q.push_back(1'b0);
                exp_cyc_q.push_back(cyc + WR_CYC);
                last_period = WR_CYC + 1;
            end else begin
                exp_q.push_back(ref_mem[addr]);
                exp_rd_q.push_back(1'b1);
                exp_cyc_q.push_back(cyc + RD_LAT + 1);
                last_period = RD_LAT + 2 + TURN_CYC;
            end
            last_acc = cyc;
        end
        req_valid = 1'b0;
        junk_inputs();
    endtask

    task automatic do_reset(input int cycles, input bit mid);
        req_valid = 1'b0;
        rst_n     = 1'b0;
        exp_q.delete();
        exp_rd_q.delete();
        exp_cyc_q.delete();
        cur_acc     = -1000;
        last_acc    = -1000;
        last_period = 0;
        last_rd     = '0;
        n_wr_model  = 0;
        n_rd_model  = 0;
        if (mid) begin
            #1;
            check("async_wr_en_drop", mem_wr_en, 0);
            check("async_bus_release", mem_data_io, keep_val);
            check("async_done", done, 0);
        end
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_wr_en", mem_wr_en, 0);
        check("rst_re_en", mem_re_en, 0);
        check("rst_done", done, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_bus", mem_data_io, keep_val);
`ifdef RAM_CTRL_STATS_EN
        check("rst_wr_count", wr_count, 0);
        check("rst_rd_count", rd_count, 0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < DEEP; i++) begin
            ram_mem[i] = init_word(i);
            ref_mem[i] = init_word(i);
        end
        do_reset(3, 1'b0);
        mon_en = 1'b1;

        // single write then read of the same word
        do_req(1'b1, 9'h005, 32'hdead_beef);
        idle(2);
        do_req(1'b0, 9'h005, '0);
        idle(3);

        // back-to-back with valid held: address extremes
        do_req(1'b1, 9'h000, 32'h0000_0001);
        do_req(1'b1, 9'h1ff, 32'h0000_0002);
        do_req(1'b0, 9'h1ff, '0);
        do_req(1'b0, 9'h000, '0);
        idle(4);

        // abort a write with reset one cycle into it
        do_req(1'b1, 9'h007, 32'h1234_5678);
        @(posedge clk);
        #2;
        do_reset(2, 1'b1);
        idle(2);
        do_req(1'b0, 9'h007, '0);

        // random mix, addresses clustered to get read-after-write hits
        for (int t = 0; t < 80; t++) begin
            logic [AW-1:0] a;
            a = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            do_req(1'($urandom_range(0, 1)), a, $urandom);
            idle($urandom_range(0, 2));
        end

        // drain outstanding completions
        for (int k = 0; k < 40 && exp_cyc_q.size() > 0; k++) begin
            @(posedge clk);
            #1;
        end
        idle(2);
        check("drain_empty", exp_cyc_q.size(), 0);
`ifdef RAM_CTRL_STATS_EN
        check("wr_count", wr_count, n_wr_model[15:0]);
        check("rd_count", rd_count, n_rd_model[15:0]);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ram_ctrl.md
Name: ram_ctrl

Overview:
- Initiator-side controller for the single-port shared-bus RAM. The RAM has wr_en, re_en, addr and a bidirectional data bus.
- Accepts simple valid/ready requests from a client and sequences the RAM strobes and the data bus.
- Owns bus direction and turnaround. It drives the bus only during writes and releases it during reads, with idle cycles after each read so the bus is never contended.
- Returns read data with a one-cycle done pulse.

Parameters:
- DATA_WIDE, 32, data bus width
- DEEP, 512, RAM depth in words
- ADDR_WIDE, $clog2(DEEP), address width
- WR_CYC, 2, cycles wr_en and write data are held (>=1)
- RD_LAT, 2, cycles from re_en assertion to data sample point (>=1)
- TURN_CYC, 1, idle cycles after a read before the next request is accepted (>=0)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  client request valid
- req_ready  out  1  controller can accept a request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDE  request address
- req_wdata  in  DATA_WIDE  write data
- done  out  1  one-cycle completion pulse (read and write)
- rd_valid  out  1  one-cycle pulse; rd_data valid
- rd_data  out  DATA_WIDE  read result, held until next read completes
- mem_wr_en  out  1  RAM write strobe
- mem_re_en  out  1  RAM read strobe
- mem_addr  out  ADDR_WIDE  RAM address
- mem_data_io  inout  DATA_WIDE  shared RAM data bus

Behaviour:
- Reset values: all outputs 0 except req_ready=1. mem_data_io is Z. The FSM is in IDLE. Reset is async: strobes drop and the bus tri-states immediately.
- FSM states: IDLE, WRITE, READ, TURN. Every output except mem_data_io is registered. The bus drive enable is a registered flag, and it is 1 only in WRITE.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready at edge E0, capture req_addr to mem_addr and req_wdata to wdata_q.
  - req_we=1 goes to WRITE with cnt=WR_CYC-1; otherwise goes to READ with cnt=RD_LAT.
  - req_ready=0 from E0.
- WRITE:
  - mem_wr_en=1, mem_re_en=0, mem_data_io=wdata_q for exactly WR_CYC cycles after E0.
  - cnt decrements each cycle. At cnt==0, go to IDLE, deassert wr_en and release the bus on the same edge, and pulse done=1 for one cycle with req_ready=1.
- READ:
  - mem_re_en=1, mem_wr_en=0, bus released for RD_LAT+1 cycles.
  - At the edge ending the last cycle (cnt==0), sample mem_data_io into rd_data, pulse rd_valid=1 and done=1 for one cycle, and deassert re_en.
  - Go to TURN if TURN_CYC>0, else IDLE.
- TURN: all strobes 0, bus released, req_ready=0 for TURN_CYC cycles, then IDLE.
- mem_addr holds the last captured address between transactions. It never changes mid-transaction.
- Back-to-back:
  - Write→any: next accept on the cycle done is high, so the minimum write period is WR_CYC+1 cycles.
  - Read→any: minimum period is RD_LAT+2+TURN_CYC cycles.
- Request inputs while req_ready=0 are ignored; the client holds the request.
- wr_en and re_en are never high together.
- rd_data is unchanged by writes.
- Reset mid-transaction aborts it: no done pulse, no rd_valid, and the RAM contents of an aborted write are undefined.

Optional Feature:
- Macro: RAM_CTRL_STATS_EN.
- Defined:
  - Adds output ports wr_count[15:0] and rd_count[15:0], reset 0.
  - Each increments on its done pulse and wraps from 16'hFFFF to 0.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset with rst_n=0 for 3 cycles → req_ready=1; wr_en, re_en, done, rd_valid = 0; mem_data_io=Z. Asserting rst_n mid-WRITE drops wr_en and releases the bus in the same cycle.
- Write addr 9'h005, data 32'hDEADBEEF (defaults) → wr_en=1 and bus=DEADBEEF for 2 cycles, mem_addr=5, done pulse on cycle 3, req_ready back to 1 the same cycle.
- Read addr 9'h005 after that write → re_en=1 for 3 cycles, bus Z from controller, rd_valid=1 with rd_data=32'hDEADBEEF, then 1 TURN cycle with req_ready=0.
- Write 9'h000=1, 9'h1FF=2, then read 9'h1FF, then read 9'h000, with req_valid held continuously → reads return 2 then 1. At no cycle are wr_en and re_en high together, and the controller never drives the bus while re_en=1.
- TURN_CYC=0, RD_LAT=1 → read followed immediately by write: write accepted on the rd_valid cycle, and wr_en rises the next cycle.
- RAM_CTRL_STATS_EN defined → after 3 writes and 2 reads, wr_count=3 and rd_count=2. Preloading 16'hFFFF and doing 1 write gives wr_count=0.
